// File: rtl/pa_ifu_ras.sv
// Return address stack for the IFU ID-prediction stage: push on calls, predict on returns.
// Optional build macro PA_IFU_RAS_OVERFLOW_WRAP_EN lets a push into a full stack overwrite the oldest entry.
module pa_ifu_ras #(
  parameter int DEPTH = 4
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        id_ras_upd_vld,
  input  logic        ifu_ras_flush,
  input  logic [31:0] id_pred_pc,
  input  logic        id_pred_inst0_32,
  input  logic        id_pred_link_vld0,
  input  logic        id_pred_link_vld1,
  input  logic        id_pred_ret_vld0,
  input  logic        id_pred_ret_vld1,
  output logic        ras_ret_vld,
  output logic [31:0] ras_ret_pc,
  output logic        ras_empty,
  output logic        ras_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP
  } ras_op_e;

  logic [31:0]   entry [DEPTH];
  logic [PW-1:0] top;
  logic [CW-1:0] cnt;

  logic          slot0_hit;
  logic          act_link;
  logic          act_ret;
  logic [31:0]   seq_pc;
  logic [31:0]   ret_addr;
  logic [PW-1:0] top_inc;
  logic [PW-1:0] top_dec;
  logic          push_ok;
  ras_op_e       op;

  // Inst0 redirects when it carries a link or return, so inst1 flags only count otherwise.
  assign slot0_hit = id_pred_link_vld0 | id_pred_ret_vld0;
  assign act_link  = slot0_hit ? id_pred_link_vld0 : id_pred_link_vld1;
  assign act_ret   = slot0_hit ? id_pred_ret_vld0  : id_pred_ret_vld1;

  // Inst1 is always a 16-bit instruction, so its fall-through is two bytes past inst0's.
  assign seq_pc   = {id_pred_pc[31:1], 1'b0} + (id_pred_inst0_32 ? 32'd4 : 32'd2);
  assign ret_addr = slot0_hit ? seq_pc : seq_pc + 32'd2;

  // Explicit wrap keeps the pointer legal when DEPTH is not a power of two.
  assign top_inc = (top == PW'(DEPTH - 1)) ? '0 : top + PW'(1);
  assign top_dec = (top == '0) ? PW'(DEPTH - 1) : top - PW'(1);

  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CW'(DEPTH));

`ifdef PA_IFU_RAS_OVERFLOW_WRAP_EN
  assign push_ok = 1'b1;
`else
  assign push_ok = ~ras_full;
`endif

  // NOTE: combinational blocks assign a default first so no path leaves op unassigned (no latch).
  always_comb begin
    op = RAS_NOP;
    case ({act_link, act_ret})
      2'b10:   op = RAS_PUSH;
      2'b01:   op = ras_empty ? RAS_NOP  : RAS_POP;
      2'b11:   op = ras_empty ? RAS_PUSH : RAS_SWAP;
      default: op = RAS_NOP;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the entry array is reset too so
  // ras_ret_pc reads a defined zero straight out of reset.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      top <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (ifu_ras_flush) begin
      top <= '0;
      cnt <= '0;
    end else if (id_ras_upd_vld) begin
      case (op)
        RAS_PUSH: begin
          if (push_ok) begin
            top            <= top_inc;
            entry[top_inc] <= ret_addr;
            if (!ras_full) cnt <= cnt + CW'(1);
          end
        end
        RAS_POP: begin
          top <= top_dec;
          cnt <= cnt - CW'(1);
        end
        RAS_SWAP: entry[top] <= ret_addr;
        default: ;
      endcase
    end
  end

  assign ras_ret_pc  = entry[top];
  assign ras_ret_vld = act_ret & ~ras_empty;

endmodule

// File: tb/tb_pa_ifu_ras.sv
// Scoreboard bench for pa_ifu_ras: directed packets queue their expected outputs,
// a negedge monitor pops and compares. Mirrors PA_IFU_RAS_OVERFLOW_WRAP_EN expectations.
module tb_pa_ifu_ras;

  typedef struct {
    string       name;
    logic        vld;
    logic [31:0] pc;
    logic        empty;
    logic        full;
  } exp_t;

`ifdef PA_IFU_RAS_OVERFLOW_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        i32 = 1'b0;
  logic        l0 = 1'b0, l1 = 1'b0, r0 = 1'b0, r1 = 1'b0;
  logic        ret_vld;
  logic [31:0] ret_pc;
  logic        empty, full;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb [$];

  pa_ifu_ras #(.DEPTH(4)) dut (
    .forever_cpuclk    (clk),
    .cpurst            (rst),
    .id_ras_upd_vld    (upd),
    .ifu_ras_flush     (flush),
    .id_pred_pc        (pc),
    .id_pred_inst0_32  (i32),
    .id_pred_link_vld0 (l0),
    .id_pred_link_vld1 (l1),
    .id_pred_ret_vld0  (r0),
    .id_pred_ret_vld1  (r1),
    .ras_ret_vld       (ret_vld),
    .ras_ret_pc        (ret_pc),
    .ras_empty         (empty),
    .ras_full          (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".vld"},   32'(ret_vld), 32'(e.vld));
        check({e.name, ".pc"},    ret_pc,       e.pc);
        check({e.name, ".empty"}, 32'(empty),   32'(e.empty));
        check({e.name, ".full"},  32'(full),    32'(e.full));
      end
    end
  end

  // Present one packet for one cycle and queue what the outputs must show during it.
  task automatic step(input string name, input logic [31:0] p, input logic is32,
                      input logic a_l0, input logic a_r0, input logic a_l1, input logic a_r1,
                      input logic a_upd, input logic a_flush,
                      input logic e_vld, input logic [31:0] e_pc, input logic e_empty,
                      input logic e_full);
    exp_t e;
    @(posedge clk);
    #1;
    pc = p; i32 = is32; l0 = a_l0; r0 = a_r0; l1 = a_l1; r1 = a_r1;
    upd = a_upd; flush = a_flush;
    e.name = name; e.vld = e_vld; e.pc = e_pc; e.empty = e_empty; e.full = e_full;
    sb.push_back(e);
  endtask

  initial begin
    int wait_cyc;
    //    name        pc           32  l0 r0 l1 r1 upd fl   vld pc           emp full
    step("reset",    32'h0,        0, 0, 0, 0, 0, 0, 0,   0, 32'h0,        1, 0);
    @(posedge clk); #1; rst = 1'b0;
    step("call0",    32'h8000_0000,1, 1, 0, 0, 0, 1, 0,   0, 32'h0,        1, 0);
    step("ret0",     32'h0,        1, 0, 1, 0, 0, 1, 0,   1, 32'h8000_0004,0, 0);
    step("popped",   32'h0,        0, 0, 0, 0, 0, 0, 0,   0, 32'h0,        1, 0);
    step("call1",    32'h100,      0, 0, 0, 1, 0, 1, 0,   0, 32'h0,        1, 0);
    step("r0_l1",    32'h200,      0, 0, 1, 1, 0, 1, 0,   1, 32'h104,      0, 0);
    step("no_l1",    32'h0,        0, 0, 0, 0, 0, 0, 0,   0, 32'h0,        1, 0);
    // fill with return addresses 0x10..0x40, then one push past full
    step("push10",   32'hC,        1, 1, 0, 0, 0, 1, 0,   0, 32'h0,        1, 0);
    step("push20",   32'h1C,       1, 1, 0, 0, 0, 1, 0,   0, 32'h10,       0, 0);
    step("push30",   32'h2C,       1, 1, 0, 0, 0, 1, 0,   0, 32'h20,       0, 0);
    step("push40",   32'h3C,       1, 1, 0, 0, 0, 1, 0,   0, 32'h30,       0, 0);
    step("push50",   32'h4C,       1, 1, 0, 0, 0, 1, 0,   0, 32'h40,       0, 1);
    step("pop1",     32'h0,        0, 0, 1, 0, 0, 1, 0,   1, WRAP ? 32'h50 : 32'h40, 0, 1);
    step("pop2",     32'h0,        0, 0, 1, 0, 0, 1, 0,   1, WRAP ? 32'h40 : 32'h30, 0, 0);
    step("pop3",     32'h0,        0, 0, 1, 0, 0, 1, 0,   1, WRAP ? 32'h30 : 32'h20, 0, 0);
    step("pop4",     32'h0,        0, 0, 1, 0, 0, 1, 0,   1, WRAP ? 32'h20 : 32'h10, 0, 0);
    step("pop5",     32'h0,        0, 0, 1, 0, 0, 0, 0,   0, WRAP ? 32'h50 : 32'h40, 1, 0);
    // coroutine swap on top entry 0x20
    step("push_sw",  32'h1C,       1, 1, 0, 0, 0, 1, 0,   0, WRAP ? 32'h50 : 32'h40, 1, 0);
    step("swap",     32'h300,      0, 1, 1, 0, 0, 1, 0,   1, 32'h20,       0, 0);
    step("swapped",  32'h0,        0, 0, 0, 0, 0, 0, 0,   0, 32'h302,      0, 0);
    // stalled call held for five cycles must push once
    for (int i = 0; i < 5; i++)
      step("stall",  32'h4FC,      1, 1, 0, 0, 0, 0, 0,   0, 32'h302,      0, 0);
    step("stall_go", 32'h4FC,      1, 1, 0, 0, 0, 1, 0,   0, 32'h302,      0, 0);
    step("peek500",  32'h0,        0, 0, 1, 0, 0, 0, 0,   1, 32'h500,      0, 0);
    step("pop500",   32'h0,        0, 0, 1, 0, 0, 1, 0,   1, 32'h500,      0, 0);
    step("pop302",   32'h0,        0, 0, 1, 0, 0, 1, 0,   1, 32'h302,      0, 0);
    // flush beats a simultaneous call
    step("push600",  32'h5FC,      1, 1, 0, 0, 0, 1, 0,   0, WRAP ? 32'h50 : 32'h40, 1, 0);
    step("flush",    32'h6FC,      1, 1, 0, 0, 0, 1, 1,   0, 32'h600,      0, 0);
    step("flushed",  32'h0,        0, 0, 1, 0, 0, 0, 0,   0, 32'h40,       1, 0);
    // asynchronous reset in the middle of a sequence
    step("push700",  32'h6FC,      1, 1, 0, 0, 0, 1, 0,   0, 32'h40,       1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    step("async_rst",32'h0,        0, 0, 0, 0, 0, 0, 0,   0, 32'h0,        1, 0);
    step("post_rst", 32'h7FC,      1, 1, 0, 0, 0, 1, 0,   0, 32'h0,        1, 0);
    rst = 1'b0;
    step("peek800",  32'h0,        0, 0, 1, 0, 0, 0, 0,   1, 32'h800,      0, 0);
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
